apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB master that drives the timer IP's APB slave port. Converts a simple
//  valid/ready command interface (single read or write) into compliant APB SETUP/ACCESS
//  phases. Returns read data, PSLVERR and a wait-state timeout as a one-cycle response.
//  Sits between the CPU-side command source and the timer's PSEL/PENABLE/PADDR port.
// PARAMETERS
//  ADDR_W   8   APB address width (PADDR, cmd_addr)
//  DATA_W   8   APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
//  TIMEOUT  16  max ACCESS cycles with PREADY low before abort; 0 = never abort
// PORTS
//  PCLK         in   1       clock; all logic on rising edge
//  PRESETn      in   1       synchronous reset, active-low
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       bridge accepts command (transfer on valid&ready)
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  target register address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       one-cycle pulse: transfer finished (no backpressure)
//  rsp_rdata    out  DATA_W  read data; 0 for writes and timeouts
//  rsp_err      out  1       PSLVERR seen at completion, or timeout
//  rsp_timeout  out  1       transfer aborted by TIMEOUT
//  PSEL         out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction
//  PADDR        out  ADDR_W  APB address
//  PWDATA       out  DATA_W  APB write data
//  PRDATA       in   DATA_W  APB read data
//  PREADY       in   1       APB ready
//  PSLVERR      in   1       APB slave error
// BEHAVIOUR
//  - Reset (PRESETn=0 at edge): state IDLE; all outputs 0 except cmd_ready=1 one cycle after
//    release; wait counter 0. Reset mid-transfer: PSEL/PENABLE drop at that edge, no rsp.
//  - States: IDLE -> SETUP -> ACCESS -> IDLE. All outputs registered.
//  - IDLE: cmd_ready=1. On cmd_valid at edge N: latch write/addr/wdata into PWRITE/PADDR/
//    PWDATA, go SETUP; cycle N+1 PSEL=1, PENABLE=0, cmd_ready=0.
//  - SETUP: unconditional -> ACCESS; cycle N+2 PSEL=1, PENABLE=1.
//  - ACCESS, PREADY=1 at edge: -> IDLE; next cycle PSEL=0, PENABLE=0, rsp_valid=1,
//    rsp_err=PSLVERR, rsp_rdata = PWRITE ? 0 : PRDATA, rsp_timeout=0, cmd_ready=1.
//    Minimum transfer: 3 cycles from acceptance to rsp_valid; next accept same cycle as rsp.
//  - ACCESS, PREADY=0: wait counter +1; PWRITE/PADDR/PWDATA held stable.
//    If TIMEOUT!=0 and counter reaches TIMEOUT (PREADY still 0): -> IDLE, rsp_valid=1,
//    rsp_err=1, rsp_timeout=1, rsp_rdata=0. PREADY=1 on the same edge wins (normal completion).
//  - Wait counter width $clog2(TIMEOUT+1), saturating; cleared on entry to SETUP.
//  - PWRITE/PADDR/PWDATA keep last values in IDLE (no toggling); PWDATA not updated on reads.
//  - rsp_* fields are valid only while rsp_valid=1; rsp_valid never asserted two cycles in a row.
//  - PSLVERR/PRDATA are ignored except on the completing ACCESS edge.
// STRUCTURE
//  - Shared header apb_defs.vh: state encodings (IDLE/SETUP/ACCESS), timer register map
//    constants (TCR=8'h00, TDR=8'h01, TSR=8'h02), default widths.
//  - Sub-module apb_wait_timer: wait counter + timeout flag (clear, inc, expired).
//  - Top: FSM, address/data latches, response registers.
// TESTING
//  1 Write TDR: cmd addr=0x01 wdata=0xFA, timer PREADY=1 -> SETUP at N+1, ACCESS at N+2,
//    rsp_valid at N+3, rsp_err=0; timer TDR reads back 0xFA.
//  2 Read TCR after writing 0x91 then 0x11 -> rsp_rdata=0x11, rsp_err=0, PWRITE=0 throughout.
//  3 Slave inserts 3 wait states -> PENABLE high 4 cycles, PADDR/PWDATA stable, rsp at 4th+1.
//  4 PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rdata=0.
//  5 PSLVERR=1 with PREADY=1 on write to 0xFF -> rsp_err=1, rsp_timeout=0.
//  6 PRESETn=0 during ACCESS -> PSEL/PENABLE 0 next edge, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge: FSM encoding,
// default widths and the timer IP register map.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    localparam logic [7:0] TCR_ADDR = 8'h00;
    localparam logic [7:0] TDR_ADDR = 8'h01;
    localparam logic [7:0] TSR_ADDR = 8'h02;

    // TIMEOUT=0 still needs a 1-bit counter so the vector stays legal.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus bundle; "master" is the bridge
// view, "slave" is the view of whatever surrounds it (CPU side and timer).
interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// Saturating ACCESS wait-state counter; o_expired flags the increment that
// would bring the count up to TIMEOUT.
module apb_master_bridge_wait_timer
    import apb_master_bridge_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);
    localparam int            CW   = wait_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && i_inc && (r_count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB SETUP/ACCESS master with registered outputs,
// one-cycle response pulse and optional wait-state timeout.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_master_bridge_if.master bus
);
    state_t            r_state,     w_state_next;
    logic              r_psel,      w_psel_next;
    logic              r_penable,   w_penable_next;
    logic              r_pwrite,    w_pwrite_next;
    logic [ADDR_W-1:0] r_paddr,     w_paddr_next;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata_next;
    logic              r_cmd_ready, w_cmd_ready_next;
    logic              r_rsp_valid, w_rsp_valid_next;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_next;
    logic              r_rsp_err,   w_rsp_err_next;
    logic              r_rsp_to,    w_rsp_to_next;
    logic              w_tmr_clear;
    logic              w_tmr_inc;
    logic              w_expired;

    apb_master_bridge_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .i_clear   (w_tmr_clear),
        .i_inc     (w_tmr_inc),
        .o_expired (w_expired)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_pwrite    <= w_pwrite_next;
            r_paddr     <= w_paddr_next;
            r_pwdata    <= w_pwdata_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
            r_rsp_to    <= w_rsp_to_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_psel_next      = r_psel;
        w_penable_next   = r_penable;
        w_pwrite_next    = r_pwrite;
        w_paddr_next     = r_paddr;
        w_pwdata_next    = r_pwdata;
        w_cmd_ready_next = r_cmd_ready;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = '0;
        w_rsp_err_next   = 1'b0;
        w_rsp_to_next    = 1'b0;
        w_tmr_clear      = 1'b0;
        w_tmr_inc        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_psel_next      = 1'b0;
                w_penable_next   = 1'b0;
                w_cmd_ready_next = 1'b1;
                // Accept only once cmd_ready is already visible, so the first
                // cycle after reset release never takes a command.
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state_next     = ST_SETUP;
                    w_psel_next      = 1'b1;
                    w_cmd_ready_next = 1'b0;
                    w_pwrite_next    = bus.cmd_write;
                    w_paddr_next     = bus.cmd_addr;
                    w_tmr_clear      = 1'b1;
                    if (bus.cmd_write) begin
                        w_pwdata_next = bus.cmd_wdata;
                    end
                end
            end
            ST_SETUP: begin
                w_state_next   = ST_ACCESS;
                w_penable_next = 1'b1;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    w_state_next     = ST_IDLE;
                    w_psel_next      = 1'b0;
                    w_penable_next   = 1'b0;
                    w_cmd_ready_next = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = bus.PSLVERR;
                    w_rsp_rdata_next = r_pwrite ? '0 : bus.PRDATA;
                end else begin
                    w_tmr_inc = 1'b1;
                    if (w_expired) begin
                        w_state_next     = ST_IDLE;
                        w_psel_next      = 1'b0;
                        w_penable_next   = 1'b0;
                        w_cmd_ready_next = 1'b1;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_rsp_to_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_psel_next    = 1'b0;
                w_penable_next = 1'b0;
            end
        endcase
    end

    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a behavioural timer slave with programmable
// wait states/errors, and a register-map reference model for expectations.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Timer slave: answers after cfg_waits ACCESS cycles, or never when stuck.
    logic [DW-1:0] slv_mem [256];
    logic [DW-1:0] ref_mem [256];
    int cfg_waits = 0;
    bit cfg_err   = 0;
    bit cfg_stuck = 0;
    int acc_cnt   = 0;

    always @(negedge clk) begin
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
            if (!cfg_stuck && acc_cnt >= cfg_waits) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = cfg_err;
                bus.PRDATA  = slv_mem[bus.PADDR];
                if (bus.PWRITE && !cfg_err) slv_mem[bus.PADDR] = bus.PWDATA;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = DW'($urandom);
                bus.PSLVERR = 1'($urandom);
            end
            acc_cnt++;
        end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = DW'($urandom);
            acc_cnt     = 0;
        end
    end

    // Observations of the most recent transfer (cycle 1 = first cycle after accept).
    int            o_count, o_pen, o_acc_cyc, o_rsp_cyc;
    bit            o_setup_ok, o_stable, o_end_ok, o_got;
    logic [DW-1:0] o_rdata;
    logic          o_err, o_to;

    // Issues one command; called and returns at a negedge (the response cycle).
    task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input bit err, input bit stuck);
        bit done;
        cfg_waits = waits; cfg_err = err; cfg_stuck = stuck;
        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'($urandom);
        bus.cmd_addr = AW'($urandom); bus.cmd_wdata = DW'($urandom);
        o_count = 1; o_pen = 0; o_got = 0; o_stable = 1; o_end_ok = 0; o_acc_cyc = cyc;
        o_setup_ok = (bus.PSEL === 1'b1) && (bus.PENABLE === 1'b0) && (bus.cmd_ready === 1'b0);
        done = 0;
        while (!done && o_count < 100) begin
            if (bus.rsp_valid === 1'b1) begin
                o_got = 1; o_rsp_cyc = cyc; done = 1;
                o_rdata = bus.rsp_rdata; o_err = bus.rsp_err; o_to = bus.rsp_timeout;
                o_end_ok = (bus.PSEL === 1'b0) && (bus.PENABLE === 1'b0) && (bus.cmd_ready === 1'b1);
            end else begin
                if (bus.PENABLE === 1'b1) o_pen++;
                if (bus.PSEL === 1'b1 && (bus.PADDR !== a || bus.PWRITE !== w ||
                    (w && bus.PWDATA !== d))) o_stable = 0;
                @(negedge clk);
                o_count++;
            end
        end
        if (w && !err && !stuck && waits < TO) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid, bus.PWRITE} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid, bus.PWRITE});
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.PADDR, bus.PWDATA, bus.rsp_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.cmd_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_tdr();
        xfer(1'b1, TDR_ADDR, 8'hFA, 0, 1'b0, 1'b0);
        checks++;
        if (!o_got || o_count !== 3 || !o_setup_ok || o_pen !== 1) begin
            failures++;
            $display("FAIL wr_tdr_timing got=count%0d pen%0d setup%0b exp=count3 pen1 setup1", o_count, o_pen, o_setup_ok);
        end
        checks++;
        if ({o_err, o_to, o_rdata, o_end_ok} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL wr_tdr_rsp got=err%b to%b rd%h end%b exp=err0 to0 rd00 end1", o_err, o_to, o_rdata, o_end_ok);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.PADDR !== TDR_ADDR || bus.PWDATA !== 8'hFA) begin
            failures++;
            $display("FAIL wr_tdr_after got=rv%b addr%h wd%h exp=rv0 addr01 wdFA", bus.rsp_valid, bus.PADDR, bus.PWDATA);
        end
        xfer(1'b0, TDR_ADDR, 8'h00, 0, 1'b0, 1'b0);
        checks++;
        if (!o_got || o_rdata !== 8'hFA || o_err !== 1'b0 || o_count !== 3) begin
            failures++;
            $display("FAIL rd_tdr got=rd%h err%b count%0d exp=rdFA err0 count3", o_rdata, o_err, o_count);
        end
        $display("test_write_tdr done");
    endtask

    task automatic test_read_tcr();
        xfer(1'b1, TCR_ADDR, 8'h91, 0, 1'b0, 1'b0);
        xfer(1'b1, TCR_ADDR, 8'h11, 0, 1'b0, 1'b0);
        xfer(1'b0, TCR_ADDR, DW'($urandom), 1, 1'b0, 1'b0);
        checks++;
        if (!o_got || o_rdata !== 8'h11 || o_err !== 1'b0 || !o_stable) begin
            failures++;
            $display("FAIL rd_tcr got=rd%h err%b stable%b exp=rd11 err0 stable1", o_rdata, o_err, o_stable);
        end
        checks++;
        if (bus.PWDATA !== 8'h11 || bus.PWRITE !== 1'b0) begin
            failures++;
            $display("FAIL rd_tcr_pwdata got=wd%h pw%b exp=wd11 pw0", bus.PWDATA, bus.PWRITE);
        end
        $display("test_read_tcr done");
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] a = AW'($urandom);
        logic [DW-1:0] d = DW'($urandom);
        xfer(1'b1, a, d, 3, 1'b0, 1'b0);
        checks++;
        if (!o_got || o_pen !== 4 || o_count !== 6 || !o_stable || o_err !== 1'b0) begin
            failures++;
            $display("FAIL wait3 got=pen%0d count%0d stable%b err%b exp=pen4 count6 stable1 err0", o_pen, o_count, o_stable, o_err);
        end
        xfer(1'b0, a, 8'h00, 2, 1'b0, 1'b0);
        checks++;
        if (o_rdata !== d || o_count !== 5) begin
            failures++;
            $display("FAIL wait2_read got=rd%h count%0d exp=rd%h count5", o_rdata, o_count, d);
        end
        $display("test_wait_states done");
    endtask

    task automatic test_timeout();
        logic [AW-1:0] a = TSR_ADDR;
        xfer(1'b0, a, 8'h00, 0, 1'b0, 1'b1);
        checks++;
        if (!o_got || o_count !== TO + 2 || o_pen !== TO) begin
            failures++;
            $display("FAIL timeout_timing got=count%0d pen%0d exp=count%0d pen%0d", o_count, o_pen, TO + 2, TO);
        end
        checks++;
        if ({o_err, o_to, o_rdata, o_end_ok} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL timeout_rsp got=err%b to%b rd%h end%b exp=err1 to1 rd00 end1", o_err, o_to, o_rdata, o_end_ok);
        end
        // PREADY arriving on the last allowed cycle must complete normally.
        xfer(1'b0, a, 8'h00, TO - 1, 1'b0, 1'b0);
        checks++;
        if (!o_got || o_count !== TO + 2 || o_to !== 1'b0 || o_err !== 1'b0 || o_rdata !== ref_mem[a]) begin
            failures++;
            $display("FAIL timeout_edge got=count%0d to%b err%b rd%h exp=count%0d to0 err0 rd%h", o_count, o_to, o_err, o_rdata, TO + 2, ref_mem[a]);
        end
        $display("test_timeout done");
    endtask

    task automatic test_slverr();
        xfer(1'b1, 8'hFF, DW'($urandom), 0, 1'b1, 1'b0);
        checks++;
        if (!o_got || o_err !== 1'b1 || o_to !== 1'b0 || o_rdata !== 8'h00 || o_count !== 3) begin
            failures++;
            $display("FAIL slverr got=err%b to%b rd%h count%0d exp=err1 to0 rd00 count3", o_err, o_to, o_rdata, o_count);
        end
        xfer(1'b0, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
        checks++;
        if (o_rdata !== ref_mem[8'hFF] || o_err !== 1'b0) begin
            failures++;
            $display("FAIL slverr_readback got=rd%h err%b exp=rd%h err0", o_rdata, o_err, ref_mem[8'hFF]);
        end
        $display("test_slverr done");
    endtask

    task automatic test_back_to_back();
        int first_rsp;
        xfer(1'b1, 8'h10, 8'h5A, 0, 1'b0, 1'b0);
        first_rsp = o_rsp_cyc;
        xfer(1'b1, 8'h11, 8'hA5, 0, 1'b0, 1'b0);
        checks++;
        if (o_acc_cyc !== first_rsp + 1 || o_count !== 3) begin
            failures++;
            $display("FAIL b2b_accept got=acc%0d count%0d exp=acc%0d count3", o_acc_cyc, o_count, first_rsp + 1);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 40; n++) begin
            bit            w   = 1'($urandom);
            logic [AW-1:0] a   = AW'($urandom_range(0, 15));
            logic [DW-1:0] d   = DW'($urandom);
            int            wt  = $urandom_range(0, 5);
            bit            err = ($urandom_range(0, 3) == 0);
            logic [DW-1:0] exp_rd = w ? 8'h00 : ref_mem[a];
            xfer(w, a, d, wt, err, 1'b0);
            checks++;
            if (!o_got || o_count !== 3 + wt || o_pen !== wt + 1 || !o_stable || !o_setup_ok ||
                o_rdata !== exp_rd || o_err !== err || o_to !== 1'b0 || !o_end_ok) begin
                failures++; bad++;
                $display("FAIL rand%0d got=count%0d pen%0d stable%b rd%h err%b to%b exp=count%0d pen%0d stable1 rd%h err%b to0",
                         n, o_count, o_pen, o_stable, o_rdata, o_err, o_to, 3 + wt, wt + 1, exp_rd, err);
            end
        end
        $display("test_random done errors=%0d", bad);
    endtask

    task automatic test_reset_mid();
        bit saw_rsp = 0;
        cfg_stuck = 1'b1;
        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = TSR_ADDR; bus.cmd_wdata = 8'h3C;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.PENABLE !== 1'b1) begin
            failures++;
            $display("FAIL midrst_access got=%b exp=1", bus.PENABLE);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_drop got=%b exp=0000", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready});
        end
        rst_n = 1'b1;
        cfg_stuck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) saw_rsp = 1;
        end
        checks++;
        if (saw_rsp || bus.cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_release got=spurious%b ready%b exp=spurious0 ready1", saw_rsp, bus.cmd_ready);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = DW'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        test_reset();
        test_write_tdr();
        test_read_tcr();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
